// File: rtl/binary_to_gray.sv
// binary_to_gray: registered binary<->Gray converter with a Gray adjacency monitor.
//
// One word is accepted per cycle under in_valid. The converted word appears on G
// one clock later, qualified by out_valid. adj_ok flags that the Gray-domain view of
// the new result differs in exactly one bit from the previous accepted word of the
// same mode.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   B and mode are sampled when high
//   mode       0 = binary->Gray, 1 = Gray->binary
//   B          input code word
//   G          converted word (registered, holds while idle)
//   out_valid  G carries the result of the previous cycle's accepted input
//   adj_ok     current result is one bit away from the previous same-mode result
module binary_to_gray #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             mode,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] G,
   output logic             out_valid,
   output logic             adj_ok
);

   logic [WIDTH-1:0] bin_to_gray;
   logic [WIDTH-1:0] gray_to_bin;
   logic [WIDTH-1:0] conv;
   logic [WIDTH-1:0] gray_dom;
   logic [WIDTH-1:0] diff;
   logic             acc;
   logic             one_bit;
   logic             adj_next;

   // History of the previous accepted word, always kept in the Gray domain.
   logic [WIDTH-1:0] prev_q;
   logic             prev_mode_q;
   logic             has_prev_q;

   always_comb begin
      bin_to_gray = B ^ (B >> 1);

      // Prefix XOR from the MSB down gives the binary value of a Gray word.
      gray_to_bin = '0;
      acc         = 1'b0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc            = acc ^ B[i];
         gray_to_bin[i] = acc;
      end

      conv     = mode ? gray_to_bin : bin_to_gray;
      // In Gray->binary mode the input itself is the Gray word.
      gray_dom = mode ? B : bin_to_gray;

      diff     = gray_dom ^ prev_q;
      // Exactly one bit set: non-zero and a power of two.
      one_bit  = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
      adj_next = one_bit && has_prev_q && (prev_mode_q == mode);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         G           <= '0;
         out_valid   <= 1'b0;
         adj_ok      <= 1'b0;
         prev_q      <= '0;
         prev_mode_q <= 1'b0;
         has_prev_q  <= 1'b0;
      end else if (in_valid) begin
         G           <= conv;
         out_valid   <= 1'b1;
         adj_ok      <= adj_next;
         prev_q      <= gray_dom;
         prev_mode_q <= mode;
         has_prev_q  <= 1'b1;
      end else begin
         // Idle: G holds, history is kept.
         out_valid <= 1'b0;
         adj_ok    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_binary_to_gray.sv
module tb_binary_to_gray;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       mode;
   logic [3:0] B;
   logic [3:0] G;
   logic       out_valid;
   logic       adj_ok;

   int n_cmp;
   int n_err;

   // Hand-computed 4-bit Gray codes for binary 0..15.
   logic [3:0] gray_tab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                                 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                                 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                 4'b1010, 4'b1011, 4'b1001, 4'b1000};

   binary_to_gray #(.WIDTH(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .mode      (mode),
      .B         (B),
      .G         (G),
      .out_valid (out_valid),
      .adj_ok    (adj_ok)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs and return #1 after the sampling edge.
   task automatic step(input logic r, input logic v, input logic m, input logic [3:0] b);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      mode     = m;
      B        = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b0, 4'b0101);
      step(1'b1, 1'b1, 1'b0, 4'b0101);
      n_cmp++; if (G !== 4'b0000) begin n_err++; $display("FAIL reset_g: got %b want 0000", G); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_cmp++; if (adj_ok !== 1'b0) begin n_err++; $display("FAIL reset_adj: got %b want 0", adj_ok); end
      step(1'b0, 1'b0, 1'b0, 4'b0000);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_noemit: got %b want 0", out_valid); end
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 1'b0, 4'(i));
         n_cmp++;
         if (G !== gray_tab[i]) begin
            n_err++; $display("FAIL sweep_g[%0d]: got %b want %b", i, G, gray_tab[i]);
         end
         n_cmp++;
         if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL sweep_valid[%0d]: got %b want 1", i, out_valid);
         end
         n_cmp++;
         if (adj_ok !== (i != 0)) begin
            n_err++; $display("FAIL sweep_adj[%0d]: got %b want %b", i, adj_ok, (i != 0));
         end
      end
   endtask

   task automatic test_wrap();
      step(1'b0, 1'b1, 1'b0, 4'b1111);
      n_cmp++; if (G !== 4'b1000) begin n_err++; $display("FAIL wrap_g1: got %b want 1000", G); end
      step(1'b0, 1'b1, 1'b0, 4'b0000);
      n_cmp++; if (G !== 4'b0000) begin n_err++; $display("FAIL wrap_g0: got %b want 0000", G); end
      n_cmp++; if (adj_ok !== 1'b1) begin n_err++; $display("FAIL wrap_adj: got %b want 1", adj_ok); end
   endtask

   task automatic test_inverse();
      step(1'b0, 1'b1, 1'b1, 4'b1100);
      n_cmp++; if (G !== 4'b1000) begin n_err++; $display("FAIL inv_1100: got %b want 1000", G); end
      n_cmp++; if (adj_ok !== 1'b0) begin n_err++; $display("FAIL inv_adj_modechg: got %b want 0", adj_ok); end
      step(1'b0, 1'b1, 1'b1, 4'b1000);
      n_cmp++; if (G !== 4'b1111) begin n_err++; $display("FAIL inv_1000: got %b want 1111", G); end
      n_cmp++; if (adj_ok !== 1'b1) begin n_err++; $display("FAIL inv_adj_1bit: got %b want 1", adj_ok); end
      step(1'b0, 1'b1, 1'b1, 4'b0111);
      n_cmp++; if (G !== 4'b0101) begin n_err++; $display("FAIL inv_0111: got %b want 0101", G); end
      n_cmp++; if (adj_ok !== 1'b0) begin n_err++; $display("FAIL inv_adj_4bit: got %b want 0", adj_ok); end
   endtask

   task automatic test_roundtrip();
      for (int i = 0; i < 16; i++) begin
         step(1'b0, 1'b1, 1'b0, 4'(i));
         n_cmp++;
         if (G !== gray_tab[i]) begin
            n_err++; $display("FAIL rt_fwd[%0d]: got %b want %b", i, G, gray_tab[i]);
         end
         step(1'b0, 1'b1, 1'b1, gray_tab[i]);
         n_cmp++;
         if (G !== 4'(i)) begin
            n_err++; $display("FAIL rt_back[%0d]: got %b want %b", i, G, 4'(i));
         end
      end
   endtask

   task automatic test_idle();
      step(1'b0, 1'b1, 1'b0, 4'b0101);
      n_cmp++; if (G !== 4'b0111) begin n_err++; $display("FAIL idle_first_g: got %b want 0111", G); end
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 1'b0, 1'b0, 4'b1010);
         n_cmp++;
         if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid[%0d]: got %b want 0", k, out_valid); end
         n_cmp++;
         if (G !== 4'b0111) begin n_err++; $display("FAIL idle_hold[%0d]: got %b want 0111", k, G); end
         n_cmp++;
         if (adj_ok !== 1'b0) begin n_err++; $display("FAIL idle_adj[%0d]: got %b want 0", k, adj_ok); end
      end
      step(1'b0, 1'b1, 1'b0, 4'b0110);
      n_cmp++; if (G !== 4'b0101) begin n_err++; $display("FAIL idle_after_g: got %b want 0101", G); end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL idle_after_valid: got %b want 1", out_valid); end
      n_cmp++; if (adj_ok !== 1'b1) begin n_err++; $display("FAIL idle_after_adj: got %b want 1", adj_ok); end
   endtask

   task automatic test_mode_switch();
      step(1'b0, 1'b1, 1'b0, 4'b0011);
      n_cmp++; if (G !== 4'b0010) begin n_err++; $display("FAIL ms_fwd_g: got %b want 0010", G); end
      step(1'b0, 1'b1, 1'b1, 4'b0011);
      n_cmp++; if (G !== 4'b0010) begin n_err++; $display("FAIL ms_inv_g: got %b want 0010", G); end
      n_cmp++; if (adj_ok !== 1'b0) begin n_err++; $display("FAIL ms_adj_modechg: got %b want 0", adj_ok); end
      step(1'b0, 1'b1, 1'b1, 4'b0011);
      n_cmp++; if (G !== 4'b0010) begin n_err++; $display("FAIL ms_rep_g: got %b want 0010", G); end
      n_cmp++; if (adj_ok !== 1'b0) begin n_err++; $display("FAIL ms_adj_repeat: got %b want 0", adj_ok); end
   endtask

   task automatic test_back_to_back_reset();
      // 0010 -> Gray 0011; without reset 0011 (Gray 0010) would be adjacent.
      step(1'b0, 1'b1, 1'b0, 4'b0010);
      n_cmp++; if (G !== 4'b0011) begin n_err++; $display("FAIL mid_pre_g: got %b want 0011", G); end
      step(1'b1, 1'b1, 1'b0, 4'b0001);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b want 0", out_valid); end
      n_cmp++; if (G !== 4'b0000) begin n_err++; $display("FAIL mid_rst_g: got %b want 0000", G); end
      step(1'b0, 1'b1, 1'b0, 4'b0011);
      n_cmp++; if (G !== 4'b0010) begin n_err++; $display("FAIL mid_post_g: got %b want 0010", G); end
      n_cmp++; if (adj_ok !== 1'b0) begin n_err++; $display("FAIL mid_post_adj: got %b want 0", adj_ok); end
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      in_valid = 1'b0;
      mode     = 1'b0;
      B        = 4'b0000;
      test_reset();
      test_sweep();
      test_wrap();
      test_inverse();
      test_roundtrip();
      test_idle();
      test_mode_switch();
      test_back_to_back_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/binary_to_gray.md
Name: binary_to_gray

Overview:
- Registered, parameterised binary-to-Gray code converter, with a selectable Gray-to-binary inverse mode.
- Used wherever counters or pointers cross domains or feed encoders: pointer encoding, position sensors, status displays.
- Accepts one word per cycle under a valid strobe and produces the converted word one clock later.
- Monitors successive Gray outputs for single-bit adjacency.

Parameters:
- WIDTH, 4, data word width in bits; legal range ≥ 2.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  B/mode are sampled this cycle when high.
- mode  input  1  0 = binary→Gray, 1 = Gray→binary.
- B  input  WIDTH  input code word.
- G  output  WIDTH  converted word, registered.
- out_valid  output  1  G holds a result produced from the previous cycle's accepted input.
- adj_ok  output  1  current result is exactly one bit away from the previous valid result of the same mode.

Behaviour:
- Reset: synchronous, active-high, sampled on the rising edge of clk.
  - On the edge where rst=1: G=0, out_valid=0, adj_ok=0.
  - The stored previous-result register and its history flag are cleared.
  - rst has priority over in_valid in the same cycle; that input is dropped.
- Binary→Gray (mode=0): G[WIDTH-1]=B[WIDTH-1]; G[i]=B[i+1]^B[i] for i<WIDTH-1; equivalently G = B ^ (B>>1).
- Gray→binary (mode=1): out[WIDTH-1]=B[WIDTH-1]; out[i]=out[i+1]^B[i], evaluated MSB down to LSB. The result is driven on G.
- Conversion is purely combinational internally; the result is registered.
- Latency: exactly 1 clock, from in_valid sampled high to out_valid high with the result on G.
- Throughput: one word per cycle, no back-pressure.
- in_valid=0:
  - out_valid drops to 0 on the next edge.
  - G holds its last value (no return to zero).
  - adj_ok drops to 0.
- Adjacency monitor:
  - Compares the Gray-domain word with the Gray-domain word of the previous accepted input.
  - Gray-domain word = G when mode=0; the input B when mode=1.
  - adj_ok=1 iff the popcount of their XOR equals 1 AND a previous accepted word exists since reset AND the mode is the same as for the previous word.
  - The first accepted word after reset, and the first after a mode change, give adj_ok=0.
  - An identical repeated input gives adj_ok=0 (distance 0).
  - Idle gaps (in_valid=0) do not clear the history.
- Wrap-around: the binary sequence all-ones→zero is a single-bit Gray change (for WIDTH=4, 1000→0000), so it gives adj_ok=1.
- mode may change on any cycle. Each accepted word is converted with the mode sampled alongside it; there is no pipeline flush.
- Reset mid-stream: the in-flight result is discarded, out_valid=0 on the following cycle, and the history is cleared.
- All outputs are driven from flops; there is no combinational path from inputs to outputs.

Test Plan:
- Reset with in_valid=1, B=0101 → G=0000, out_valid=0, adj_ok=0 one cycle later; no result emitted.
- mode=0, sweep B=0000…1111 one per cycle (WIDTH=4):
  - G sequence: 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
  - out_valid=1 on each result.
  - adj_ok=0 on the first result, 1 on all others.
- mode=0, B=1111 then B=0000 → G=1000 then 0000, with adj_ok=1 on the wrap.
- mode=1, B=1100 → G=1000; B=1000 → G=1111; B=0111 → G=0101. Round trip of every 4-bit value through both modes recovers the original.
- mode=0, B=0101, then idle 3 cycles, then B=0110:
  - G=0111, out_valid drops during the idle cycles while G holds 0111.
  - Then G=0101 with adj_ok=1.
- Mode switch and repeat:
  - mode=0 B=0011 (G=0010), then mode=1 B=0011 → G=0010, adj_ok=0 (mode changed).
  - Then B=0011 again in mode=1 → adj_ok=0 (distance 0).
